instr_fetch: RTL and testbench
==============================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter FIFO_DEPTH, default 2, fetched-instruction buffer entries (power of 2, >=2).
REQ-002 Clk_Core  input  1  core clock; all state updates on rising edge.
REQ-003 Rst_Core_N  input  1  core reset; asynchronous, active-low.
REQ-004 Program_Count  input  32  current PC from PC register.
REQ-005 Redirect  input  1  taken branch/jump this cycle (same signal as PC_Sel); flushes fetch state.
REQ-006 Fetch_Advance  output  1  PC register enable; high when the current PC has been consumed.
REQ-007 Imem_Req_Valid  output  1  instruction memory request valid.
REQ-008 Imem_Req_Ready  input  1  memory accepts the request.
REQ-009 Imem_Req_Addr  output  32  request address.
REQ-010 Imem_Rsp_Valid  input  1  response data valid; exactly one response per accepted request, >=1 cycle later.
REQ-011 Imem_Rsp_Data  input  32  instruction word.
REQ-012 Instr_Valid  output  1  decode-side entry valid.
REQ-013 Instr_Ready  input  1  decode accepts entry.
REQ-014 Instr_Data  output  32  instruction at FIFO head.
REQ-015 Instr_PC  output  32  PC of the instruction at FIFO head.
REQ-016 Instr_Misalign  output  1  head entry is a misaligned-fetch marker.

Function
REQ-017 FSM states: S_IDLE, S_WAIT, S_DROP; at most one outstanding memory request.
REQ-018 S_IDLE: Imem_Req_Valid = ~Redirect & (fifo_count + 0 < FIFO_DEPTH); Imem_Req_Addr = Program_Count.
REQ-019 S_IDLE with Imem_Req_Valid & Imem_Req_Ready: Fetch_Advance=1 that cycle, latch request PC, go to S_WAIT.
REQ-020 Fetch_Advance SHALL be 0 in every other case.
REQ-021 S_WAIT: Imem_Req_Valid=0; on Imem_Rsp_Valid push {latched PC, Imem_Rsp_Data, 0} into FIFO, go to S_IDLE.
REQ-022 S_WAIT with Redirect and no Imem_Rsp_Valid: go to S_DROP; with Redirect and Imem_Rsp_Valid in the same cycle: discard the response, go to S_IDLE.
REQ-023 S_DROP: Imem_Req_Valid=0; the next Imem_Rsp_Valid is discarded, then go to S_IDLE.
REQ-024 Redirect SHALL clear all FIFO entries at the next edge, with priority over same-cycle push and pop.
REQ-025 Instr_Valid = FIFO non-empty; a pop occurs on Instr_Valid & Instr_Ready.
REQ-026 A pushed entry SHALL be visible on Instr_Valid one cycle after Imem_Rsp_Valid.
REQ-027 Push and pop in the same cycle SHALL be allowed, with count unchanged.
REQ-028 Requests are gated by free space, so a push SHALL never occur while the FIFO is full.
REQ-029 FIFO pointers wrap modulo FIFO_DEPTH; count width is clog2(FIFO_DEPTH)+1.
REQ-030 Instr_Data, Instr_PC and Instr_Misalign SHALL hold stable while Instr_Valid=1 and Instr_Ready=0.

Reset
REQ-031 On Rst_Core_N low: state S_IDLE, FIFO empty, latched PC 0, Instr_Valid=0, Imem_Req_Valid=0, Fetch_Advance=0, Instr_Data/Instr_PC=0, Instr_Misalign=0.
REQ-032 Reset asserted while in S_WAIT SHALL abandon the outstanding request; any stray response after release is the memory's responsibility.

Configuration
REQ-033 Macro INSTR_FETCH_MISALIGN_CHECK_EN defined: in S_IDLE with Program_Count[1:0]!=0, no memory request is issued; when space is free, a marker {Program_Count, NOP_INSTR, 1} is pushed, Fetch_Advance=1, and the state stays S_IDLE.
REQ-034 Macro INSTR_FETCH_MISALIGN_CHECK_EN undefined: Instr_Misalign is tied to 0 and the address is issued unmodified.

Structure
REQ-035 Shared package core_pkg SHALL hold XLEN=32, NOP_INSTR=32'h0000_0013, and the fetch FSM state enum.
REQ-036 The FIFO SHALL be a sub-module fetch_fifo (parameter DEPTH, flush, push, pop, full, empty, count).

Verification
REQ-037 Reset, then Program_Count=0x0, Imem_Req_Ready=1, response after 1 cycle with data 0x00500093 -> Fetch_Advance pulses once; Instr_Valid with Instr_PC=0x0 and Instr_Data=0x00500093 one cycle after the response.
REQ-038 Instr_Ready=0, back-to-back fetches -> exactly FIFO_DEPTH(=2) entries; Imem_Req_Valid=0 while full; after one pop, a new request is issued within 1 cycle.
REQ-039 Redirect asserted in S_WAIT with the response 2 cycles later -> the response is discarded, FIFO is empty, and the next request is issued at the new Program_Count.
REQ-040 Redirect in the same cycle as Imem_Rsp_Valid and an Instr_Ready pop -> FIFO is empty next cycle and no entry from that response appears.
REQ-041 Imem_Req_Ready=0 for 5 cycles -> Imem_Req_Valid held and Imem_Req_Addr stable, Fetch_Advance=0 throughout.
REQ-042 With INSTR_FETCH_MISALIGN_CHECK_EN, Program_Count=0x102 -> no Imem_Req_Valid; entry with Instr_Misalign=1, Instr_PC=0x102, Instr_Data=0x00000013.

Source files
------------

// File: rtl/core_pkg.sv
// Shared core definitions: data width, the NOP encoding, the fetch FSM
// states and the layout of one buffered fetch entry.
package core_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DROP = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] data;
    logic            misalign;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Circular buffer of fetched instructions. A flush empties it and takes
// priority over a push or pop in the same cycle.
module fetch_fifo
  import core_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic                   flush_i,
  input  logic                   push_i,
  input  fetch_entry_t           push_data_i,
  input  logic                   pop_i,
  output fetch_entry_t           pop_data_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  fetch_entry_t    mem_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q;
  logic [PW-1:0]   rd_ptr_q;
  logic [CW-1:0]   count_q;
  logic            push_en;
  logic            pop_en;

  assign full_o     = (count_q == CW'(DEPTH));
  assign empty_o    = (count_q == '0);
  assign count_o    = count_q;
  assign pop_data_o = mem_q[rd_ptr_q];
  assign push_en    = push_i & ~full_o;
  assign pop_en     = pop_i & ~empty_o;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_en) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= wr_ptr_q + PW'(1);
      end
      if (pop_en) rd_ptr_q <= rd_ptr_q + PW'(1);
      if (push_en && !pop_en)      count_q <= count_q + CW'(1);
      else if (pop_en && !push_en) count_q <= count_q - CW'(1);
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch front end: one outstanding memory request, responses
// buffered for decode. Define INSTR_FETCH_MISALIGN_CHECK_EN to turn
// misaligned PCs into marker entries instead of memory requests.
module instr_fetch
  import core_pkg::*;
#(
  parameter int FIFO_DEPTH = 2
) (
  input  logic            Clk_Core_i,
  input  logic            Rst_Core_N_i,
  input  logic [XLEN-1:0] Program_Count_i,
  input  logic            Redirect_i,
  output logic            Fetch_Advance_o,
  output logic            Imem_Req_Valid_o,
  input  logic            Imem_Req_Ready_i,
  output logic [XLEN-1:0] Imem_Req_Addr_o,
  input  logic            Imem_Rsp_Valid_i,
  input  logic [XLEN-1:0] Imem_Rsp_Data_i,
  output logic            Instr_Valid_o,
  input  logic            Instr_Ready_i,
  output logic [XLEN-1:0] Instr_Data_o,
  output logic [XLEN-1:0] Instr_PC_o,
  output logic            Instr_Misalign_o
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] req_pc_q, req_pc_d;
  logic            space_ok;
  logic            req_valid;
  logic            advance;
  logic            push;
  fetch_entry_t    push_entry;
  fetch_entry_t    head_entry;
  logic            fifo_full;
  logic            fifo_empty;
  logic [CW-1:0]   fifo_count;

  // Nothing may be requested while reset holds the block.
  assign space_ok = Rst_Core_N_i & ~Redirect_i & (fifo_count < CW'(FIFO_DEPTH));

  always_comb begin
    state_d    = state_q;
    req_pc_d   = req_pc_q;
    req_valid  = 1'b0;
    advance    = 1'b0;
    push       = 1'b0;
    push_entry = '0;
    case (state_q)
      S_IDLE: begin
`ifdef INSTR_FETCH_MISALIGN_CHECK_EN
        if (Program_Count_i[1:0] != 2'b00) begin
          if (space_ok) begin
            push       = 1'b1;
            push_entry = '{pc: Program_Count_i, data: NOP_INSTR, misalign: 1'b1};
            advance    = 1'b1;
          end
        end else begin
          req_valid = space_ok;
          if (req_valid && Imem_Req_Ready_i) begin
            advance  = 1'b1;
            req_pc_d = Program_Count_i;
            state_d  = S_WAIT;
          end
        end
`else
        req_valid = space_ok;
        if (req_valid && Imem_Req_Ready_i) begin
          advance  = 1'b1;
          req_pc_d = Program_Count_i;
          state_d  = S_WAIT;
        end
`endif
      end
      S_WAIT: begin
        if (Imem_Rsp_Valid_i) begin
          state_d = S_IDLE;
          if (!Redirect_i && !fifo_full) begin
            push       = 1'b1;
            push_entry = '{pc: req_pc_q, data: Imem_Rsp_Data_i, misalign: 1'b0};
          end
        end else if (Redirect_i) begin
          state_d = S_DROP;
        end
      end
      S_DROP: begin
        if (Imem_Rsp_Valid_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk_Core_i or negedge Rst_Core_N_i) begin
    if (!Rst_Core_N_i) begin
      state_q  <= S_IDLE;
      req_pc_q <= '0;
    end else begin
      state_q  <= state_d;
      req_pc_q <= req_pc_d;
    end
  end

  fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i       (Clk_Core_i),
    .rst_n_i     (Rst_Core_N_i),
    .flush_i     (Redirect_i),
    .push_i      (push),
    .push_data_i (push_entry),
    .pop_i       (Instr_Ready_i),
    .pop_data_o  (head_entry),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .count_o     (fifo_count)
  );

  assign Fetch_Advance_o  = advance;
  assign Imem_Req_Valid_o = req_valid;
  assign Imem_Req_Addr_o  = Program_Count_i;
  assign Instr_Valid_o    = ~fifo_empty;
  assign Instr_Data_o     = head_entry.data;
  assign Instr_PC_o       = head_entry.pc;
  // Only marker pushes ever set this bit, so without the check it is constant 0.
  assign Instr_Misalign_o = head_entry.misalign;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch; expected values are hand-computed per scenario.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] pc;
  logic        redirect;
  logic        advance;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr_data;
  logic [31:0] instr_pc;
  logic        instr_mis;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  instr_fetch #(.FIFO_DEPTH(2)) dut (
    .Clk_Core_i       (clk),
    .Rst_Core_N_i     (rst_n),
    .Program_Count_i  (pc),
    .Redirect_i       (redirect),
    .Fetch_Advance_o  (advance),
    .Imem_Req_Valid_o (req_valid),
    .Imem_Req_Ready_i (req_ready),
    .Imem_Req_Addr_o  (req_addr),
    .Imem_Rsp_Valid_i (rsp_valid),
    .Imem_Rsp_Data_i  (rsp_data),
    .Instr_Valid_o    (instr_valid),
    .Instr_Ready_i    (instr_ready),
    .Instr_Data_o     (instr_data),
    .Instr_PC_o       (instr_pc),
    .Instr_Misalign_o (instr_mis)
  );

  // Advance one clock; inputs change 1 time unit after the rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; pc = 32'h0; redirect = 1'b0; req_ready = 1'b0;
    rsp_valid = 1'b0; rsp_data = 32'h0; instr_ready = 1'b0;
    #2;
    total++; if (req_valid !== 1'b0) begin bad++; $display("FAIL reset_req_valid got=%b want=0", req_valid); end
    total++; if (advance !== 1'b0) begin bad++; $display("FAIL reset_advance got=%b want=0", advance); end
    total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL reset_instr_valid got=%b want=0", instr_valid); end
    total++; if (instr_data !== 32'h0 || instr_pc !== 32'h0 || instr_mis !== 1'b0) begin
      bad++; $display("FAIL reset_head got data=%h pc=%h mis=%b want 0/0/0", instr_data, instr_pc, instr_mis); end
    cyc(); cyc();
    rst_n = 1'b1;
    #1;
    total++; if (req_valid !== 1'b1) begin bad++; $display("FAIL post_reset_req_valid got=%b want=1", req_valid); end
  endtask

  task automatic test_basic();
    int adv_cnt = 0;
    pc = 32'h0; req_ready = 1'b1;
    #1;
    total++; if (req_valid !== 1'b1 || req_addr !== 32'h0) begin
      bad++; $display("FAIL basic_req got v=%b a=%h want 1/0", req_valid, req_addr); end
    adv_cnt += int'(advance);
    cyc();
    pc = 32'h4; req_ready = 1'b0; rsp_valid = 1'b1; rsp_data = 32'h0050_0093;
    #1;
    total++; if (req_valid !== 1'b0 || instr_valid !== 1'b0) begin
      bad++; $display("FAIL basic_wait got req_v=%b instr_v=%b want 0/0", req_valid, instr_valid); end
    adv_cnt += int'(advance);
    cyc();
    rsp_valid = 1'b0;
    #1;
    adv_cnt += int'(advance);
    total++; if (instr_valid !== 1'b1 || instr_pc !== 32'h0 || instr_data !== 32'h0050_0093) begin
      bad++; $display("FAIL basic_entry got v=%b pc=%h d=%h want 1/0/00500093", instr_valid, instr_pc, instr_data); end
    total++; if (adv_cnt !== 1) begin bad++; $display("FAIL basic_advance_pulses got=%0d want=1", adv_cnt); end
    instr_ready = 1'b1;
    cyc();
    instr_ready = 1'b0;
    #1;
    total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL basic_pop got=%b want=0", instr_valid); end
  endtask

  task automatic test_full();
    req_ready = 1'b1; instr_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      pc = 32'h100 + 32'(4 * i);
      #1;
      total++; if (req_valid !== 1'b1) begin bad++; $display("FAIL full_req%0d got=%b want=1", i, req_valid); end
      cyc();
      rsp_valid = 1'b1; rsp_data = 32'hA000_0000 + 32'(i);
      cyc();
      rsp_valid = 1'b0;
    end
    pc = 32'h108;
    for (int k = 0; k < 3; k++) begin
      #1;
      total++; if (req_valid !== 1'b0 || advance !== 1'b0) begin
        bad++; $display("FAIL full_gate%0d got v=%b adv=%b want 0/0", k, req_valid, advance); end
      total++; if (instr_valid !== 1'b1 || instr_pc !== 32'h100 || instr_data !== 32'hA000_0000) begin
        bad++; $display("FAIL full_hold%0d got v=%b pc=%h d=%h want 1/100/a0000000", k, instr_valid, instr_pc, instr_data); end
      cyc();
    end
    req_ready = 1'b0; instr_ready = 1'b1;
    cyc();
    instr_ready = 1'b0;
    #1;
    total++; if (req_valid !== 1'b1 || req_addr !== 32'h108) begin
      bad++; $display("FAIL full_after_pop_req got v=%b a=%h want 1/108", req_valid, req_addr); end
    total++; if (instr_pc !== 32'h104 || instr_data !== 32'hA000_0001) begin
      bad++; $display("FAIL full_second_head got pc=%h d=%h want 104/a0000001", instr_pc, instr_data); end
    redirect = 1'b1;
    #1;
    total++; if (req_valid !== 1'b0) begin bad++; $display("FAIL redirect_blocks_req got=%b want=0", req_valid); end
    cyc();
    redirect = 1'b0;
    #1;
    total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL idle_flush got=%b want=0", instr_valid); end
  endtask

  task automatic test_redirect_wait();
    pc = 32'h200; req_ready = 1'b1;
    cyc();
    req_ready = 1'b0; redirect = 1'b1; pc = 32'h300;
    cyc();
    redirect = 1'b0;
    #1;
    total++; if (req_valid !== 1'b0) begin bad++; $display("FAIL drop_no_req got=%b want=0", req_valid); end
    cyc();
    rsp_valid = 1'b1; rsp_data = 32'hDEAD_BEEF;
    #1;
    total++; if (req_valid !== 1'b0) begin bad++; $display("FAIL drop_rsp_no_req got=%b want=0", req_valid); end
    cyc();
    rsp_valid = 1'b0;
    #1;
    total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL drop_discard got=%b want=0", instr_valid); end
    total++; if (req_valid !== 1'b1 || req_addr !== 32'h300) begin
      bad++; $display("FAIL drop_new_req got v=%b a=%h want 1/300", req_valid, req_addr); end
  endtask

  task automatic test_redirect_rsp_pop();
    pc = 32'h400; req_ready = 1'b1;
    cyc();
    req_ready = 1'b0; rsp_valid = 1'b1; rsp_data = 32'h1111_1111;
    cyc();
    rsp_valid = 1'b0; pc = 32'h404; req_ready = 1'b1;
    cyc();
    req_ready = 1'b0; rsp_valid = 1'b1; rsp_data = 32'h2222_2222;
    redirect = 1'b1; instr_ready = 1'b1;
    #1;
    total++; if (instr_valid !== 1'b1 || instr_pc !== 32'h400) begin
      bad++; $display("FAIL rrp_pre got v=%b pc=%h want 1/400", instr_valid, instr_pc); end
    cyc();
    rsp_valid = 1'b0; redirect = 1'b0; instr_ready = 1'b0; pc = 32'h500;
    #1;
    total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL rrp_flush got=%b want=0", instr_valid); end
    total++; if (req_valid !== 1'b1 || req_addr !== 32'h500) begin
      bad++; $display("FAIL rrp_idle got v=%b a=%h want 1/500", req_valid, req_addr); end
    cyc();
    total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL rrp_no_late got=%b want=0", instr_valid); end
  endtask

  task automatic test_stall();
    pc = 32'h600; req_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      total++; if (req_valid !== 1'b1 || req_addr !== 32'h600 || advance !== 1'b0) begin
        bad++; $display("FAIL stall%0d got v=%b a=%h adv=%b want 1/600/0", k, req_valid, req_addr, advance); end
      cyc();
    end
    req_ready = 1'b1;
    #1;
    total++; if (advance !== 1'b1) begin bad++; $display("FAIL stall_accept got=%b want=1", advance); end
    cyc();
    req_ready = 1'b0; rsp_valid = 1'b1; rsp_data = 32'h3333_3333;
    cyc();
    rsp_valid = 1'b0;
    #1;
    total++; if (instr_pc !== 32'h600 || instr_data !== 32'h3333_3333) begin
      bad++; $display("FAIL stall_entry got pc=%h d=%h want 600/33333333", instr_pc, instr_data); end
    instr_ready = 1'b1;
    cyc();
    instr_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    pc = 32'h700; req_ready = 1'b1;
    cyc();
    req_ready = 1'b0; rsp_valid = 1'b1; rsp_data = 32'h7777_0000;
    cyc();
    rsp_valid = 1'b0; pc = 32'h704; req_ready = 1'b1;
    cyc();
    req_ready = 1'b0; rsp_valid = 1'b1; rsp_data = 32'h7777_0004; instr_ready = 1'b1;
    #1;
    total++; if (instr_pc !== 32'h700) begin bad++; $display("FAIL b2b_head got=%h want=700", instr_pc); end
    cyc();
    rsp_valid = 1'b0; instr_ready = 1'b0;
    #1;
    total++; if (instr_valid !== 1'b1 || instr_pc !== 32'h704 || instr_data !== 32'h7777_0004) begin
      bad++; $display("FAIL b2b_swap got v=%b pc=%h d=%h want 1/704/77770004", instr_valid, instr_pc, instr_data); end
    total++; if (req_valid !== 1'b1) begin bad++; $display("FAIL b2b_count got req_v=%b want=1", req_valid); end
    instr_ready = 1'b1;
    cyc();
    instr_ready = 1'b0;
    #1;
    total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL b2b_drain got=%b want=0", instr_valid); end
  endtask

  task automatic test_misalign();
`ifdef INSTR_FETCH_MISALIGN_CHECK_EN
    pc = 32'h102; req_ready = 1'b1;
    #1;
    total++; if (req_valid !== 1'b0 || advance !== 1'b1) begin
      bad++; $display("FAIL mis_issue got v=%b adv=%b want 0/1", req_valid, advance); end
    cyc();
    pc = 32'h104; req_ready = 1'b0;
    #1;
    total++; if (instr_valid !== 1'b1 || instr_mis !== 1'b1 || instr_pc !== 32'h102 || instr_data !== 32'h0000_0013) begin
      bad++; $display("FAIL mis_marker got v=%b m=%b pc=%h d=%h want 1/1/102/00000013", instr_valid, instr_mis, instr_pc, instr_data); end
`else
    pc = 32'h102; req_ready = 1'b0;
    #1;
    total++; if (req_valid !== 1'b1 || req_addr !== 32'h102) begin
      bad++; $display("FAIL mis_off_req got v=%b a=%h want 1/102", req_valid, req_addr); end
    req_ready = 1'b1;
    cyc();
    req_ready = 1'b0; rsp_valid = 1'b1; rsp_data = 32'h4444_4444;
    cyc();
    rsp_valid = 1'b0;
    #1;
    total++; if (instr_valid !== 1'b1 || instr_mis !== 1'b0 || instr_pc !== 32'h102) begin
      bad++; $display("FAIL mis_off_entry got v=%b m=%b pc=%h want 1/0/102", instr_valid, instr_mis, instr_pc); end
`endif
    instr_ready = 1'b1;
    cyc();
    instr_ready = 1'b0;
  endtask

  task automatic test_reset_in_wait();
    pc = 32'h800; req_ready = 1'b1;
    cyc();
    req_ready = 1'b0;
    #1;
    total++; if (req_valid !== 1'b0) begin bad++; $display("FAIL rst_wait_pre got=%b want=0", req_valid); end
    rst_n = 1'b0;
    #1;
    total++; if (req_valid !== 1'b0) begin bad++; $display("FAIL rst_wait_during got=%b want=0", req_valid); end
    cyc();
    rst_n = 1'b1;
    #1;
    total++; if (req_valid !== 1'b1 || instr_valid !== 1'b0) begin
      bad++; $display("FAIL rst_wait_after got req_v=%b instr_v=%b want 1/0", req_valid, instr_valid); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_full();
    test_redirect_wait();
    test_redirect_rsp_pop();
    test_stall();
    test_back_to_back();
    test_misalign();
    test_reset_in_wait();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
